id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode and the execute-stage ALU. Captures decoded operands, immediate, ALU op and destination info.
- Resolves operand forwarding from EX/MEM and MEM/WB and drives the ALU inputs a, b and op directly.
- Handles stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath width
- RAW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1_addr  in  RAW  source 1 register index
- id_rs2_addr  in  RAW  source 2 register index
- id_rs1_data  in  XLEN  register file read, port 1
- id_rs2_data  in  XLEN  register file read, port 2
- id_imm  in  XLEN  sign-extended immediate
- id_alu_src  in  1  1: b = immediate, 0: b = rs2
- id_alu_op  in  4  ALU operation code
- id_rd_addr  in  RAW  destination register
- id_reg_write  in  1  instruction writes rd
- exm_reg_write, exm_rd_addr, exm_result  in  1/RAW/XLEN  EX/MEM forwarding source
- wb_reg_write, wb_rd_addr, wb_result  in  1/RAW/XLEN  MEM/WB forwarding source
- stall  in  1  hold stage contents
- flush  in  1  replace contents with bubble
- ex_valid  out  1  registered valid
- ex_a  out  XLEN  ALU operand a (forwarded)
- ex_b  out  XLEN  ALU operand b (forwarded or immediate)
- ex_op  out  4  ALU op
- ex_store_data  out  XLEN  forwarded rs2, independent of alu_src
- ex_rd_addr  out  RAW  registered rd
- ex_reg_write  out  1  registered reg_write, gated by valid

Behaviour:
- Reset (async, rst_n=0):
  - All stage registers clear: valid=0, reg_write=0, op=ADD (4'b0000), rd=0, operand/imm registers=0.
  - Outputs are therefore zero except as forwarded.
- Capture (rising edge, flush=0, stall=0): register every id_* field.
  - Decode bypass at capture: if wb_reg_write && wb_rd_addr!=0 && wb_rd_addr==id_rsN_addr, store wb_result instead of id_rsN_data. The register file does not write-through.
- Stall (stall=1, flush=0): control fields hold.
  - Operand registers reload with their current forwarded values (ex_a/ex_store_data paths), so a WB value that retires during the stall is not lost.
- Flush (flush=1): wins over stall; next cycle valid=0, reg_write=0, op=ADD, operands=0.
- Forwarding (combinational on outputs), per source N in {rs1, rs2}:
  - Use exm_result if exm_reg_write && exm_rd_addr!=0 && exm_rd_addr==rsN_reg.
  - Else use wb_result on the same condition with wb_*.
  - Else use the registered data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- ex_b = imm_reg when alu_src_reg=1, else forwarded rs2.
- ex_store_data is always forwarded rs2.
- ex_reg_write = reg_write_reg & valid_reg.
- Forwarding is still evaluated when valid=0; a bubble writes nothing, so the values are harmless.
- Latency: one cycle from id_* to ex_*. Forwarding adds zero cycles.
- ex_op is passed unchanged. Undefined codes are not filtered; the ALU defaults them to zero output.

Decomposition:
- Package alu_pkg:
  - XLEN and RAW defaults.
  - ALU op constants: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_SLT=4'b0101, ALU_SLL=4'b0110.
  - REG_ZERO=0.
- One sub-module, fwd_mux:
  - Inputs: reg index, registered data, EX/MEM source, MEM/WB source.
  - Output: forwarded value.
  - Instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst_n low mid-run with valid=1 in stage -> ex_valid=0, ex_reg_write=0, ex_op=0, ex_a=ex_b=0 immediately, without waiting for clk.
- Plain capture: rs1_data=5, rs2_data=3, alu_src=0, op=SUB, no forwarding -> next cycle ex_a=5, ex_b=3, ex_op=0001, ex_valid=1.
- Double forward: rs1=r4; exm writes r4=0x11 and wb writes r4=0x22 in the same cycle -> ex_a=0x11. With exm_reg_write dropped -> ex_a=0x22.
- Zero register: rs1=r0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF -> ex_a=registered value 0.
- Stall retention:
  - Capture rs2=r7 with alu_src=1 and imm=8.
  - Stall 2 cycles; wb writes r7=0x40 in stall cycle 1 only.
  - -> ex_store_data=0x40 in both stall cycles and after release; ex_b=8 throughout.
- Flush over stall: stall=1 and flush=1 together with valid=1, reg_write=1 -> next cycle ex_valid=0, ex_reg_write=0, ex_op=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the decode/execute boundary.
//   - default datapath and register-index widths
//   - ALU operation codes (ex_op carries these unchanged to the ALU)
//   - index of the hard-wired zero register, which is never forwarded
//   - packed control bundle held in the ID/EX pipeline register
package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'b0000;
  localparam alu_op_t ALU_SUB = 4'b0001;
  localparam alu_op_t ALU_AND = 4'b0010;
  localparam alu_op_t ALU_OR  = 4'b0011;
  localparam alu_op_t ALU_SLT = 4'b0101;
  localparam alu_op_t ALU_SLL = 4'b0110;

  localparam int REG_ZERO = 0;

  // Control fields that travel with the instruction. A bubble is all-zero,
  // which also makes the op an ADD.
  typedef struct packed {
    logic    valid;
    logic    reg_write;
    logic    alu_src;
    alu_op_t op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, alu_src: 1'b0, op: ALU_ADD};

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the hazard/forwarding sources and the
// ID/EX stage.
//   id_*   : decoded instruction fields presented for capture
//   exm_*  : EX/MEM forwarding source (write enable, rd index, result)
//   wb_*   : MEM/WB forwarding source (write enable, rd index, result)
//   stall  : hold the stage contents
//   flush  : replace the stage contents with a bubble
//   ex_*   : operands and control presented to the execute-stage ALU
// modport master : the surrounding pipeline (drives id/exm/wb/stall/flush)
// modport slave  : the ID/EX stage itself
interface id_ex_stage_if
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
);

  logic            id_valid;
  logic [RAW-1:0]  id_rs1_addr;
  logic [RAW-1:0]  id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_alu_src;
  alu_op_t         id_alu_op;
  logic [RAW-1:0]  id_rd_addr;
  logic            id_reg_write;

  logic            exm_reg_write;
  logic [RAW-1:0]  exm_rd_addr;
  logic [XLEN-1:0] exm_result;

  logic            wb_reg_write;
  logic [RAW-1:0]  wb_rd_addr;
  logic [XLEN-1:0] wb_result;

  logic            stall;
  logic            flush;

  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  alu_op_t         ex_op;
  logic [XLEN-1:0] ex_store_data;
  logic [RAW-1:0]  ex_rd_addr;
  logic            ex_reg_write;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_alu_src, id_alu_op, id_rd_addr, id_reg_write,
           exm_reg_write, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_result,
           stall, flush,
    input  ex_valid, ex_a, ex_b, ex_op, ex_store_data, ex_rd_addr, ex_reg_write
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_alu_src, id_alu_op, id_rd_addr, id_reg_write,
           exm_reg_write, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_result,
           stall, flush,
    output ex_valid, ex_a, ex_b, ex_op, ex_store_data, ex_rd_addr, ex_reg_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding selector for one source register.
//   rs_addr            : source register index held in the stage
//   reg_data           : operand value held in the stage
//   exm_* / wb_*       : EX/MEM and MEM/WB result buses
//   data               : value the ALU should see for this source
// EX/MEM is younger than MEM/WB, so it wins when both target the same
// register. Register zero is hard-wired and never forwarded.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic [RAW-1:0]  rs_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exm_reg_write,
  input  logic [RAW-1:0]  exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [RAW-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  logic exm_hit;
  logic wb_hit;

  assign exm_hit = exm_reg_write && (exm_rd_addr != RAW'(REG_ZERO)) && (exm_rd_addr == rs_addr);
  assign wb_hit  = wb_reg_write  && (wb_rd_addr  != RAW'(REG_ZERO)) && (wb_rd_addr  == rs_addr);

  // NOTE: default assignment first so every path drives data; no latch.
  always_comb begin
    data = reg_data;
    if (exm_hit) begin
      data = exm_result;
    end else if (wb_hit) begin
      data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU inputs.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : id_ex_stage_if.slave (decode fields, forwarding sources,
//                stall/flush from the hazard unit, ALU-facing ex_* outputs)
// Captures the decoded instruction, then forwards EX/MEM or MEM/WB results
// combinationally onto ex_a / ex_b / ex_store_data with zero added latency.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  ctrl_t           ctrl_q;
  logic [RAW-1:0]  rd_q;
  logic [RAW-1:0]  rs1_addr_q;
  logic [RAW-1:0]  rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic            cap_wb_ok;

  // The register file does not write through, so a MEM/WB write landing in
  // the same cycle as the read must be merged here at capture.
  assign cap_wb_ok = bus.wb_reg_write && (bus.wb_rd_addr != RAW'(REG_ZERO));
  assign cap_rs1   = (cap_wb_ok && bus.wb_rd_addr == bus.id_rs1_addr) ? bus.wb_result : bus.id_rs1_data;
  assign cap_rs2   = (cap_wb_ok && bus.wb_rd_addr == bus.id_rs2_addr) ? bus.wb_result : bus.id_rs2_data;

  fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .reg_data      (rs1_data_q),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_result     (bus.wb_result),
    .data          (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .reg_data      (rs2_data_q),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_result     (bus.wb_result),
    .data          (fwd_rs2)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      rd_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (bus.flush) begin
      // Flush wins over stall. Clearing the source indices to r0 also
      // keeps forwarding from leaking values onto the bubble's operands.
      ctrl_q     <= CTRL_BUBBLE;
      rd_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (bus.stall) begin
      // Control holds; operands reload with their forwarded values so a
      // producer that retires while we wait is not lost.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else begin
      ctrl_q.valid     <= bus.id_valid;
      ctrl_q.reg_write <= bus.id_reg_write;
      ctrl_q.alu_src   <= bus.id_alu_src;
      ctrl_q.op        <= bus.id_alu_op;
      rd_q             <= bus.id_rd_addr;
      rs1_addr_q       <= bus.id_rs1_addr;
      rs2_addr_q       <= bus.id_rs2_addr;
      rs1_data_q       <= cap_rs1;
      rs2_data_q       <= cap_rs2;
      imm_q            <= bus.id_imm;
    end
  end

  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_reg_write  = ctrl_q.reg_write & ctrl_q.valid;
  assign bus.ex_op         = ctrl_q.op;
  assign bus.ex_rd_addr    = rd_q;
  assign bus.ex_a          = fwd_rs1;
  assign bus.ex_b          = ctrl_q.alu_src ? imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a vector table (capture-cycle inputs
// plus output-cycle forwarding sources, with expected ALU-side values),
// scored through an expected-result queue, followed by hand-written
// sequences for stall retention, flush-over-stall and mid-cycle reset.
module tb_id_ex_stage;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.XLEN(32), .RAW(5)) bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rs1;  logic [31:0] d1;
    logic [4:0]  rs2;  logic [31:0] d2;
    logic [31:0] imm;  logic        src;
    logic [3:0]  op;   logic [4:0]  rd;
    logic        rw;   logic        valid;
    logic        cwe;  logic [4:0]  crd;  logic [31:0] cres;
    logic        xwe;  logic [4:0]  xrd;  logic [31:0] xres;
    logic        wwe;  logic [4:0]  wrd;  logic [31:0] wres;
    logic [31:0] ea;   logic [31:0] eb;   logic [31:0] es;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, st;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        valid, rw;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(
    logic [4:0] rs1, logic [31:0] d1, logic [4:0] rs2, logic [31:0] d2,
    logic [31:0] imm, logic src, logic [3:0] op, logic [4:0] rd, logic rw, logic valid,
    logic cwe, logic [4:0] crd, logic [31:0] cres,
    logic xwe, logic [4:0] xrd, logic [31:0] xres,
    logic wwe, logic [4:0] wrd, logic [31:0] wres,
    logic [31:0] ea, logic [31:0] eb, logic [31:0] es);
    vec_t v;
    v.rs1 = rs1; v.d1 = d1; v.rs2 = rs2; v.d2 = d2; v.imm = imm; v.src = src;
    v.op = op; v.rd = rd; v.rw = rw; v.valid = valid;
    v.cwe = cwe; v.crd = crd; v.cres = cres;
    v.xwe = xwe; v.xrd = xrd; v.xres = xres;
    v.wwe = wwe; v.wrd = wrd; v.wres = wres;
    v.ea = ea; v.eb = eb; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid = 1'b0;       bus.id_reg_write = 1'b0;
    bus.id_rs1_addr = '0;      bus.id_rs2_addr = '0;
    bus.id_rs1_data = '0;      bus.id_rs2_data = '0;
    bus.id_imm = '0;           bus.id_alu_src = 1'b0;
    bus.id_alu_op = ALU_ADD;   bus.id_rd_addr = '0;
    bus.exm_reg_write = 1'b0;  bus.exm_rd_addr = '0; bus.exm_result = '0;
    bus.wb_reg_write = 1'b0;   bus.wb_rd_addr = '0;  bus.wb_result = '0;
    bus.stall = 1'b0;          bus.flush = 1'b0;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src, input logic [3:0] op,
                          input logic [4:0] rd, input logic rw, input logic valid);
    bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2; bus.id_rs2_data = d2;
    bus.id_imm = imm;      bus.id_alu_src = src;
    bus.id_alu_op = op;    bus.id_rd_addr = rd;
    bus.id_reg_write = rw; bus.id_valid = valid;
  endtask

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e;
    idle_inputs();
    rst_n = 1'b0;

    //            rs1 d1         rs2 d2      imm           src op       rd  rw v   cwe crd cres    xwe xrd xres      wwe wrd wres     ea        eb            es
    vecs.push_back(mk(1, 32'h5,   2, 32'h3,  32'h0,        0, ALU_SUB,  3, 1, 1,  0, 0, 32'h0,   0, 0, 32'h0,     0, 0, 32'h0,   32'h5,    32'h3,        32'h3));
    vecs.push_back(mk(4, 32'h99,  5, 32'h1,  32'h0,        0, ALU_ADD,  6, 1, 1,  0, 0, 32'h0,   1, 4, 32'h11,    1, 4, 32'h22,  32'h11,   32'h1,        32'h1));
    vecs.push_back(mk(4, 32'h99,  5, 32'h1,  32'h0,        0, ALU_OR,   6, 1, 1,  0, 0, 32'h0,   0, 4, 32'h11,    1, 4, 32'h22,  32'h22,   32'h1,        32'h1));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,  32'h123,      1, ALU_AND,  1, 1, 1,  0, 0, 32'h0,   1, 0, 32'hFFFF,  1, 0, 32'hEEEE,32'h0,    32'h123,      32'h0));
    vecs.push_back(mk(6, 32'hAAAA,7, 32'h7,  32'h0,        0, ALU_SLT,  8, 1, 1,  1, 6, 32'h55,  0, 0, 32'h0,     0, 0, 32'h0,   32'h55,   32'h7,        32'h7));
    vecs.push_back(mk(9, 32'h2,   9, 32'h2,  32'hFFFFFFF8, 1, ALU_SLL,  9, 1, 1,  0, 0, 32'h0,   1, 9, 32'h1234,  0, 0, 32'h0,   32'h1234, 32'hFFFFFFF8, 32'h1234));
    vecs.push_back(mk(10,32'h10,  3, 32'h33, 32'h0,        0, 4'hF,    10, 1, 0,  0, 0, 32'h0,   0, 0, 32'h0,     1,10, 32'h20,  32'h20,   32'h33,       32'h33));
    vecs.push_back(mk(11,32'hB,  12, 32'hC,  32'h0,        0, ALU_SUB, 13, 0, 1,  0, 0, 32'h0,   1,12, 32'h100,   0,11, 32'h200, 32'hB,    32'h100,      32'h100));
    vecs.push_back(mk(0, 32'h0,  14, 32'hE,  32'h0,        0, ALU_ADD,  0, 1, 1,  1, 0, 32'h77,  0, 0, 32'h0,     0, 0, 32'h0,   32'h0,    32'hE,        32'hE));
    vecs.push_back(mk(15,32'h1,  16, 32'h16, 32'h0,        0, ALU_ADD, 17, 1, 1,  1,16, 32'h600, 0, 0, 32'h0,     0, 0, 32'h0,   32'h1,    32'h600,      32'h600));

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(negedge clk);
    check("reset ex_valid",     32'(bus.ex_valid),     32'h0);
    check("reset ex_reg_write", 32'(bus.ex_reg_write), 32'h0);
    check("reset ex_op",        32'(bus.ex_op),        32'h0);
    check("reset ex_a",         bus.ex_a,              32'h0);
    check("reset ex_b",         bus.ex_b,              32'h0);
    rst_n = 1'b1;

    // Table: capture cycle (with capture-time WB), then output cycle with
    // the forwarding sources applied; the expectation is queued at drive.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      idle_inputs();
      drive_id(vecs[i].rs1, vecs[i].d1, vecs[i].rs2, vecs[i].d2, vecs[i].imm,
               vecs[i].src, vecs[i].op, vecs[i].rd, vecs[i].rw, vecs[i].valid);
      bus.wb_reg_write = vecs[i].cwe; bus.wb_rd_addr = vecs[i].crd; bus.wb_result = vecs[i].cres;
      e.a = vecs[i].ea; e.b = vecs[i].eb; e.st = vecs[i].es;
      e.op = vecs[i].op; e.rd = vecs[i].rd;
      e.valid = vecs[i].valid; e.rw = vecs[i].rw & vecs[i].valid;
      sb.push_back(e);

      @(posedge clk); #1;
      idle_inputs();
      bus.exm_reg_write = vecs[i].xwe; bus.exm_rd_addr = vecs[i].xrd; bus.exm_result = vecs[i].xres;
      bus.wb_reg_write  = vecs[i].wwe; bus.wb_rd_addr  = vecs[i].wrd; bus.wb_result  = vecs[i].wres;

      @(negedge clk);
      if (sb.size() == 0) begin
        check("scoreboard empty", 32'h0, 32'h1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d ex_a", i),          bus.ex_a,                  e.a);
        check($sformatf("v%0d ex_b", i),          bus.ex_b,                  e.b);
        check($sformatf("v%0d ex_store_data", i), bus.ex_store_data,         e.st);
        check($sformatf("v%0d ex_op", i),         32'(bus.ex_op),            32'(e.op));
        check($sformatf("v%0d ex_rd_addr", i),    32'(bus.ex_rd_addr),       32'(e.rd));
        check($sformatf("v%0d ex_valid", i),      32'(bus.ex_valid),         32'(e.valid));
        check($sformatf("v%0d ex_reg_write", i),  32'(bus.ex_reg_write),     32'(e.rw));
      end
    end

    // Stall retention: WB retires r7 in the first stall cycle only.
    @(posedge clk); #1;
    idle_inputs();
    drive_id(5'd1, 32'h0, 5'd7, 32'h3, 32'h8, 1'b1, ALU_ADD, 5'd2, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    bus.stall = 1'b1;
    bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd7; bus.wb_result = 32'h40;
    @(negedge clk);
    check("stall1 ex_store_data", bus.ex_store_data, 32'h40);
    check("stall1 ex_b",          bus.ex_b,          32'h8);
    @(posedge clk); #1;
    bus.wb_reg_write = 1'b0; bus.wb_rd_addr = '0; bus.wb_result = '0;
    @(negedge clk);
    check("stall2 ex_store_data", bus.ex_store_data, 32'h40);
    check("stall2 ex_b",          bus.ex_b,          32'h8);
    check("stall2 ex_valid",      32'(bus.ex_valid), 32'h1);
    check("stall2 ex_rd_addr",    32'(bus.ex_rd_addr), 32'h2);
    @(posedge clk); #1;
    bus.stall = 1'b0;
    @(negedge clk);
    check("release ex_store_data", bus.ex_store_data, 32'h40);
    check("release ex_b",          bus.ex_b,          32'h8);

    // Flush over stall.
    @(posedge clk); #1;
    idle_inputs();
    drive_id(5'd1, 32'h5, 5'd2, 32'h3, 32'h0, 1'b0, ALU_SUB, 5'd3, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_id(5'd1, 32'h9, 5'd2, 32'h4, 32'h0, 1'b0, ALU_AND, 5'd4, 1'b1, 1'b1);
    bus.stall = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("flush ex_valid",     32'(bus.ex_valid),     32'h0);
    check("flush ex_reg_write", 32'(bus.ex_reg_write), 32'h0);
    check("flush ex_op",        32'(bus.ex_op),        32'h0);
    check("flush ex_a",         bus.ex_a,              32'h0);

    // Asynchronous reset mid-cycle with a valid instruction in the stage.
    @(posedge clk); #1;
    drive_id(5'd1, 32'h5, 5'd2, 32'h3, 32'h0, 1'b0, ALU_SUB, 5'd3, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    check("pre-reset ex_valid", 32'(bus.ex_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async reset ex_valid",     32'(bus.ex_valid),     32'h0);
    check("async reset ex_reg_write", 32'(bus.ex_reg_write), 32'h0);
    check("async reset ex_op",        32'(bus.ex_op),        32'h0);
    check("async reset ex_a",         bus.ex_a,              32'h0);
    check("async reset ex_b",         bus.ex_b,              32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
